// File: rtl/fp_mul_arbiter.sv
// Two-requester front end for a single handshaked floating-point multiplier.
// Requests are granted round-robin, operands are streamed to the multiplier,
// and the result is returned to the requester that issued it. Every
// multiplier handshake phase is bounded by TIMEOUT cycles. An expired phase
// returns a quiet NaN and sets a sticky error flag.
module fp_mul_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_stb,
    output logic        req0_ack,
    output logic [31:0] resp0_z,
    output logic        resp0_stb,
    input  logic        resp0_ack,
    // requester 1
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_stb,
    output logic        req1_ack,
    output logic [31:0] resp1_z,
    output logic        resp1_stb,
    input  logic        resp1_ack,
    // multiplier
    output logic [31:0] mul_a,
    output logic        mul_a_stb,
    input  logic        mul_a_ack,
    output logic [31:0] mul_b,
    output logic        mul_b_stb,
    input  logic        mul_b_ack,
    input  logic [31:0] mul_z,
    input  logic        mul_z_stb,
    output logic        mul_z_ack,
    // status
    output logic        busy,
    output logic        timeout_err
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEND_A = 3'd1;
    localparam logic [2:0] ST_SEND_B = 3'd2;
    localparam logic [2:0] ST_WAIT_Z = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [DATA_W-1:0] QNAN     = 32'hFFC0_0000;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              last_grant;   // requester served most recently
    logic              gnt_q;        // requester owning the transaction in flight
    logic              grant;        // combinational pick in IDLE
    logic [CNT_W-1:0]  phase_cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic              timeout_q;

    logic              in_idle;
    logic              in_phase;
    logic              req_xfer;
    logic              phase_xfer;
    logic              phase_abort;
    logic              resp_done;

    assign in_idle  = (state == ST_IDLE);
    assign in_phase = (state == ST_SEND_A) || (state == ST_SEND_B) || (state == ST_WAIT_Z);

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        if (req0_stb && req1_stb) begin
            grant = ~last_grant;
        end else if (req1_stb) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

    // Request acks are held low while reset is asserted even though the
    // state already reads IDLE.
    assign req0_ack = rst_n && in_idle && req0_stb && !grant;
    assign req1_ack = rst_n && in_idle && req1_stb && grant;
    assign req_xfer = (req0_stb && req0_ack) || (req1_stb && req1_ack);

    assign mul_a_stb = (state == ST_SEND_A);
    assign mul_b_stb = (state == ST_SEND_B);
    assign mul_z_ack = (state == ST_WAIT_Z);
    assign mul_a     = mul_a_stb ? op_a : '0;
    assign mul_b     = mul_b_stb ? op_b : '0;

    assign resp0_stb = (state == ST_RESP) && !gnt_q;
    assign resp1_stb = (state == ST_RESP) && gnt_q;
    assign resp0_z   = resp0_stb ? result : '0;
    assign resp1_z   = resp1_stb ? result : '0;

    assign busy        = !in_idle;
    assign timeout_err = timeout_q;

    assign phase_xfer = (mul_a_stb && mul_a_ack) ||
                        (mul_b_stb && mul_b_ack) ||
                        (mul_z_ack && mul_z_stb);
    assign phase_abort = in_phase && !phase_xfer && (phase_cnt == CNT_LAST);
    assign resp_done   = (resp0_stb && resp0_ack) || (resp1_stb && resp1_ack);

    // Next-state decode; an expired multiplier phase jumps straight to RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_xfer) state_nxt = ST_SEND_A;
            ST_SEND_A: if (mul_a_ack) state_nxt = ST_SEND_B;
                       else if (phase_abort) state_nxt = ST_RESP;
            ST_SEND_B: if (mul_b_ack) state_nxt = ST_WAIT_Z;
                       else if (phase_abort) state_nxt = ST_RESP;
            ST_WAIT_Z: if (mul_z_stb || phase_abort) state_nxt = ST_RESP;
            ST_RESP:   if (resp_done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_xfer) begin
                gnt_q <= grant;
            end
            if (resp_done) begin
                last_grant <= gnt_q;
            end
        end
    end

    // Phase watchdog: restarts on every state change, counts in multiplier phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (state_nxt != state) begin
            phase_cnt <= '0;
        end else if (in_phase) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // Operand capture on request, result capture from multiplier or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (req_xfer) begin
                op_a <= grant ? req1_a : req0_a;
                op_b <= grant ? req1_b : req0_b;
            end
            if (mul_z_ack && mul_z_stb) begin
                result <= mul_z;
            end else if (phase_abort) begin
                result    <= QNAN;
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: a handshaked multiplier model plus a scoreboard
// of expected responses filled as requests are accepted.
module tb_fp_mul_arbiter;

    localparam int TMO = 16;
    localparam logic [31:0] QNAN = 32'hFFC00000;

    logic        clk;
    logic        rst_n;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_stb, req1_stb, req0_ack, req1_ack;
    logic [31:0] resp0_z, resp1_z;
    logic        resp0_stb, resp1_stb, resp0_ack, resp1_ack;
    logic [31:0] mul_a, mul_b, mul_z;
    logic        mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_z_stb, mul_z_ack;
    logic        busy, timeout_err;

    typedef struct {
        int          idx;
        logic [31:0] z;
    } exp_t;

    exp_t sb_q[$];
    int   order[$];
    int   errors = 0;
    int   checks = 0;

    // multiplier model controls
    logic        a_ack_en;
    bit          m_hang;
    int          m_lat;
    logic [31:0] m_a, m_b;
    bit          m_pend;
    int          m_cnt;

    fp_mul_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
        .resp0_z(resp0_z), .resp0_stb(resp0_stb), .resp0_ack(resp0_ack),
        .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
        .resp1_z(resp1_z), .resp1_stb(resp1_stb), .resp1_ack(resp1_ack),
        .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
        .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating single-precision multiply, valid for normal operands
    // whose product stays normal.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(150, 100));
        return r;
    endfunction

    assign mul_a_ack = a_ack_en;
    assign mul_b_ack = 1'b1;

    // Multiplier model: takes A then B, answers m_lat cycles later unless hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_z_stb <= 1'b0;
            mul_z     <= '0;
            m_pend    <= 1'b0;
            m_cnt     <= 0;
        end else begin
            if (mul_a_stb && mul_a_ack) m_a <= mul_a;
            if (mul_b_stb && mul_b_ack) begin
                m_b    <= mul_b;
                m_pend <= !m_hang;
                m_cnt  <= m_lat;
            end else if (m_pend) begin
                if (m_cnt == 0) begin
                    mul_z_stb <= 1'b1;
                    mul_z     <= fmul(m_a, m_b);
                    m_pend    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (mul_z_stb && mul_z_ack) mul_z_stb <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        order.delete();
    endtask

    // Present one request and push its expected response when it is accepted.
    task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] z, output int waited);
        bit done = 0;
        waited = 0;
        if (idx == 0) begin req0_a = a; req0_b = b; req0_stb = 1'b1; end
        else          begin req1_a = a; req1_b = b; req1_stb = 1'b1; end
        while (!done && waited < 200) begin
            #1;
            if ((idx == 0 ? req0_ack : req1_ack) === 1'b1) begin
                @(posedge clk);
                sb_q.push_back('{idx, z});
                order.push_back(idx);
                done = 1;
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        if (idx == 0) req0_stb = 1'b0; else req1_stb = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL req%0d_accept: got no ack in %0d cycles, expected ack", idx, waited);
        end
    endtask

    // Wait for n responses, compare with the scoreboard, optionally stall the ack.
    task automatic collect(input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            int          w;
            int          got;
            exp_t        e;
            logic [31:0] z0;
            bit          bad;
            w = 0;
            bad = 0;
            while (!(resp0_stb === 1'b1 || resp1_stb === 1'b1) && w < 400) begin
                if (busy === 1'b1 && (req0_ack !== 1'b0 || req1_ack !== 1'b0)) bad = 1;
                @(negedge clk);
                #1;
                w++;
            end
            checks++;
            if (!(resp0_stb === 1'b1 || resp1_stb === 1'b1)) begin
                errors++;
                $display("FAIL resp_wait: got no resp_stb after %0d cycles, expected one", w);
                return;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL req_ack_busy: got req ack while busy, expected 0");
            end
            checks++;
            if (resp0_stb === 1'b1 && resp1_stb === 1'b1) begin
                errors++;
                $display("FAIL resp_onehot: got both resp_stb high, expected one");
            end
            got = (resp0_stb === 1'b1) ? 0 : 1;
            z0  = (got == 0) ? resp0_z : resp1_z;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got response on %0d, expected none", got);
                return;
            end
            e = sb_q.pop_front();
            checks++;
            if (got != e.idx) begin
                errors++;
                $display("FAIL resp_port: got resp%0d, expected resp%0d", got, e.idx);
            end
            checks++;
            if (z0 !== e.z) begin
                errors++;
                $display("FAIL resp_z: got %h, expected %h", z0, e.z);
            end
            if (hold > 0) begin
                bad = 0;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    #1;
                    if ((got == 0 ? resp0_stb : resp1_stb) !== 1'b1) bad = 1;
                    if ((got == 0 ? resp0_z : resp1_z) !== z0) bad = 1;
                    if (req0_ack !== 1'b0 || req1_ack !== 1'b0) bad = 1;
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL resp_hold: got resp/ack change during %0d-cycle stall, expected stable", hold);
                end
            end
            if (got == 0) resp0_ack = 1'b1; else resp1_ack = 1'b1;
            @(negedge clk);
            resp0_ack = 1'b0;
            resp1_ack = 1'b0;
            #1;
            checks++;
            if (resp0_stb !== 1'b0 || resp1_stb !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL resp_release: got stb0=%b stb1=%b busy=%b, expected 0 0 0",
                         resp0_stb, resp1_stb, busy);
            end
        end
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        req0_stb = 1'b1;
        req0_a = 32'h3F800000;
        req0_b = 32'h3F800000;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req0_ack, req1_ack, resp0_stb, resp1_stb, mul_a_stb, mul_b_stb, mul_z_ack,
             busy, timeout_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000000",
                     {req0_ack, req1_ack, resp0_stb, resp1_stb, mul_a_stb, mul_b_stb,
                      mul_z_ack, busy, timeout_err});
        end
        checks++;
        if ({resp0_z, resp1_z, mul_a, mul_b} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 0", {resp0_z, resp1_z, mul_a, mul_b});
        end
        req0_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // a strobe withdrawn before the edge must not start a transaction
        @(negedge clk);
        req1_stb = 1'b1;
        #2;
        req1_stb = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_stb: got busy=%b, expected 0", busy);
        end
        w = 0;
    endtask

    task automatic test_single();
        int w;
        do_reset();
        m_lat = 0;
        drive_req(0, 32'h40000000, 32'h40400000, 32'h40C00000, w);
        #1;
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL first_grant: got %0d wait cycles, expected 0", w);
        end
        checks++;
        if (mul_a_stb !== 1'b1 || mul_a !== 32'h40000000) begin
            errors++;
            $display("FAIL send_a: got stb=%b a=%h, expected 1 40000000", mul_a_stb, mul_a);
        end
        collect(1, 0);
    endtask

    task automatic test_random();
        int w;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            m_lat = $urandom_range(4, 0);
            drive_req(i % 2, a, b, fmul(a, b), w);
            collect(1, 0);
        end
    endtask

    task automatic test_round_robin();
        int w0, w1;
        logic [31:0] a0, b0, a1, b1;
        do_reset();
        m_lat = 1;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                a0 = rnd_fp();
                b0 = rnd_fp();
                drive_req(0, a0, b0, fmul(a0, b0), w0);
                collect(1, 0);
                order.delete();
            end
            a0 = rnd_fp(); b0 = rnd_fp(); a1 = rnd_fp(); b1 = rnd_fp();
            fork
                drive_req(0, a0, b0, fmul(a0, b0), w0);
                drive_req(1, a1, b1, fmul(a1, b1), w1);
                collect(2, 0);
            join
            checks++;
            if (order.size() != 2 || order[0] != (p == 2 ? 1 : 0) || order[1] != (p == 2 ? 0 : 1)) begin
                errors++;
                $display("FAIL rr_order_%0d: got %0d,%0d (n=%0d), expected %0d,%0d", p,
                         order[0], order[1], order.size(), (p == 2 ? 1 : 0), (p == 2 ? 0 : 1));
            end
            order.delete();
        end
    endtask

    task automatic test_hold_off();
        int w;
        bit bad;
        logic [31:0] a0, b0;
        m_lat = 2;
        a0 = rnd_fp();
        b0 = rnd_fp();
        drive_req(0, a0, b0, fmul(a0, b0), w);
        req1_a = 32'h40800000;
        req1_b = 32'h40000000;
        req1_stb = 1'b1;
        bad = 0;
        w = 0;
        #1;
        while (resp0_stb !== 1'b1 && w < 100) begin
            if (req1_ack !== 1'b0) bad = 1;
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL req1_blocked: got req1_ack high during req0 transaction, expected 0");
        end
        collect(1, 10);
        checks++;
        if (req1_ack !== 1'b1) begin
            errors++;
            $display("FAIL req1_grant: got req1_ack=%b in IDLE, expected 1", req1_ack);
        end
        @(posedge clk);
        sb_q.push_back('{1, 32'h41000000});
        @(negedge clk);
        req1_stb = 1'b0;
        collect(1, 0);
    endtask

    task automatic test_timeout();
        int w, zc;
        logic [31:0] a, b;
        m_hang = 1'b1;
        drive_req(0, 32'h40000000, 32'h40400000, QNAN, w);
        zc = 0;
        w = 0;
        #1;
        while (resp0_stb !== 1'b1 && w < 100) begin
            if (mul_z_ack === 1'b1) zc++;
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (zc != TMO) begin
            errors++;
            $display("FAIL wait_z_timeout: got %0d cycles in WAIT_Z, expected %0d", zc, TMO);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %b, expected 1", timeout_err);
        end
        collect(1, 0);
        m_hang = 1'b0;
        a_ack_en = 1'b0;
        drive_req(1, 32'h3F800000, 32'h3F800000, QNAN, w);
        zc = 0;
        w = 0;
        #1;
        while (resp1_stb !== 1'b1 && w < 100) begin
            if (mul_a_stb === 1'b1) zc++;
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (zc != TMO) begin
            errors++;
            $display("FAIL send_a_timeout: got %0d cycles in SEND_A, expected %0d", zc, TMO);
        end
        collect(1, 0);
        a_ack_en = 1'b1;
        a = rnd_fp();
        b = rnd_fp();
        drive_req(0, a, b, fmul(a, b), w);
        collect(1, 0);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b, expected 1", timeout_err);
        end
    endtask

    task automatic test_reset_midop();
        int w;
        bit bad;
        m_lat = 30;
        drive_req(0, rnd_fp(), rnd_fp(), 32'h0, w);
        w = 0;
        #1;
        while (mul_z_ack !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (mul_z_ack !== 1'b1) begin
            errors++;
            $display("FAIL reach_wait_z: got mul_z_ack=%b, expected 1", mul_z_ack);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, mul_z_ack, mul_a_stb, mul_b_stb, resp0_stb, resp1_stb, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected 0000000",
                     {busy, mul_z_ack, mul_a_stb, mul_b_stb, resp0_stb, resp1_stb, timeout_err});
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        m_lat = 1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (resp0_stb !== 1'b0 || resp1_stb !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_resp_after_reset: got activity after release, expected idle");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_a = '0; req0_b = '0; req0_stb = 1'b0;
        req1_a = '0; req1_b = '0; req1_stb = 1'b0;
        resp0_ack = 1'b0; resp1_ack = 1'b0;
        a_ack_en = 1'b1;
        m_hang = 1'b0;
        m_lat = 0;
        test_reset();
        test_single();
        test_random();
        test_round_robin();
        test_hold_off();
        test_timeout();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion by 300000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1024, cycles allowed per multiplier handshake phase before abort.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0_a, req0_b  input  32  requester 0 operands, IEEE-754 single.
REQ-005 Port: req0_stb  input  1 / req0_ack  output  1  requester 0 request handshake.
REQ-006 Port: req1_a, req1_b, req1_stb (inputs), req1_ack (output)  same as requester 0.
REQ-007 Port: resp0_z  output  32 / resp0_stb  output  1 / resp0_ack  input  1  requester 0 result handshake.
REQ-008 Port: resp1_z, resp1_stb (outputs), resp1_ack (input)  same as requester 0.
REQ-009 Port: mul_a  output  32 / mul_a_stb  output  1 / mul_a_ack  input  1  multiplier operand A channel.
REQ-010 Port: mul_b  output  32 / mul_b_stb  output  1 / mul_b_ack  input  1  multiplier operand B channel.
REQ-011 Port: mul_z  input  32 / mul_z_stb  input  1 / mul_z_ack  output  1  multiplier result channel.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: timeout_err  output  1  sticky timeout flag.

Function
REQ-014 Every channel transfers on a rising edge where stb and ack are both high; stb, once raised, holds with stable data until the transfer.
REQ-015 FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
REQ-016 IDLE: grant chosen combinationally from the pending req*_stb lines, round-robin; the requester not granted last wins ties; a single pending requester wins outright.
REQ-017 req*_ack high only in IDLE and only for the granted requester; combinational from state, last-grant register and req*_stb.
REQ-018 IDLE request transfer: operands captured into op_a/op_b, grant index latched, state -> SEND_A; mul_a_stb high the following cycle.
REQ-019 SEND_A: mul_a=op_a, mul_a_stb=1; on mul_a_ack -> SEND_B.
REQ-020 SEND_B: mul_b=op_b, mul_b_stb=1; on mul_b_ack -> WAIT_Z.
REQ-021 WAIT_Z: mul_z_ack=1; on mul_z_stb, capture mul_z into result register -> RESP.
REQ-022 RESP: resp_stb high for the granted requester only, resp_z=result; on its resp_ack, last-grant updated, state -> IDLE; no new grant in that same cycle.
REQ-023 Non-granted resp_stb, req_ack, and all mul_* strobes/acks not listed for the current state are 0.
REQ-024 Phase counter: cleared on every state change; increments each cycle in SEND_A, SEND_B, WAIT_Z.
REQ-025 Counter reaching TIMEOUT-1 with no transfer: result=32'hFFC00000 (quiet NaN), timeout_err set, state -> RESP.
REQ-026 timeout_err is cleared only by reset.
REQ-027 Minimum request-to-response latency: 3 cycles plus multiplier latency; throughput one operation in flight.
REQ-028 Requester dropping req_stb in IDLE before a transfer leaves no state change.

Reset
REQ-029 rst_n low: state=IDLE, last-grant=1 (requester 0 favoured first), counter=0, timeout_err=0, all stb/ack outputs 0, data outputs 0, asynchronously.
REQ-030 Reset mid-operation abandons the transaction with no response; the multiplier is reset alongside by the integrator.
REQ-031 Deassertion of rst_n is synchronised externally; first grant possible on the first edge after release.

Verification
REQ-032 Req0 a=32'h40000000, b=32'h40400000, multiplier model -> resp0_z=32'h40C00000, resp0_stb only, resp1_stb stays 0.
REQ-033 Both stb high after reset -> req0 served first, then req1; next simultaneous pair -> req0 again (alternation).
REQ-034 Req1 holds stb during req0's transaction -> req1_ack stays 0 until IDLE; then req1 granted.
REQ-035 TIMEOUT=16, multiplier never raises mul_z_stb -> after 16 cycles in WAIT_Z, resp_z=32'hFFC00000, timeout_err=1, remains 1 after the next good transaction.
REQ-036 rst_n low during WAIT_Z -> all outputs 0 immediately, busy=0, no resp_stb after release.
REQ-037 resp0_ack held low 10 cycles -> resp0_stb and resp0_z stable, req1_ack 0 throughout.
